// File: rtl/alu_pkg.sv
// Shared execute-stage types: ALU opcodes, operand/memory-control bundles,
// divider FSM states and the default iteration count.
package alu_pkg;

  localparam int DIV_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } ex_state_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLL,
    ALU_SRL,
    ALU_MUL,
    ALU_DIV
  } control_e;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] mem_size;
  } memc_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } in_t;

  // Signed overflow from operand and result sign bits; SUB flips the sign test on b.
  function automatic logic signed_ovf(input logic a_s, input logic b_s,
                                      input logic r_s, input logic is_sub);
    if (is_sub) signed_ovf = (a_s != b_s) && (r_s != a_s);
    else        signed_ovf = (a_s == b_s) && (r_s != a_s);
  endfunction

endpackage

// File: rtl/stage_two_iter_divider.sv
// Iterative engine for stage_two: restoring unsigned divider (one quotient bit per
// cycle) and, when STAGE_TWO_ITER_MUL_EN is defined upstream, a shift-add multiplier.
module iter_divider
  import alu_pkg::*;
#(
  parameter int CYCLES = DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_mul,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result
);

  localparam int CW = $clog2(CYCLES + 1);

  ex_state_e     r_state;
  logic [CW-1:0] r_count;
  logic [15:0]   r_rem;
  logic [15:0]   r_quot;
  logic [15:0]   r_opnd;
  logic          r_mul;

  logic [16:0] w_shift;
  logic [17:0] w_diff;
  logic [16:0] w_sum;
  logic [15:0] w_rem_nxt;
  logic [15:0] w_quot_nxt;
  logic        w_unused_bit;

  // Divide: shift {rem,quot} left and trial-subtract. Multiply: {rem,quot} is the
  // product register, quot holds the multiplier and shifts right as bits retire.
  always_comb begin
    w_shift    = {r_rem, r_quot[15]};
    w_diff     = {1'b0, w_shift} - {2'b00, r_opnd};
    w_sum      = {1'b0, r_rem} + (r_quot[0] ? {1'b0, r_opnd} : 17'd0);
    w_rem_nxt  = w_diff[15:0];
    w_quot_nxt = {r_quot[14:0], 1'b1};
    if (r_mul) begin
      w_rem_nxt  = w_sum[16:1];
      w_quot_nxt = {w_sum[0], r_quot[15:1]};
    end else if (w_diff[17]) begin
      w_rem_nxt  = w_shift[15:0];
      w_quot_nxt = {r_quot[14:0], 1'b0};
    end
  end

  // A non-negative trial difference always fits 16 bits, so bit 16 carries nothing.
  assign w_unused_bit = w_diff[16];

  // NOTE: sequential state is written only with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_rem   <= '0;
      r_quot  <= '0;
      r_opnd  <= '0;
      r_mul   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= RUN;
            r_count <= CW'(CYCLES);
            r_rem   <= '0;
            r_mul   <= i_mul;
            r_quot  <= i_mul ? i_b : i_a;
            r_opnd  <= i_mul ? i_a : i_b;
          end
        end
        RUN: begin
          r_rem   <= w_rem_nxt;
          r_quot  <= w_quot_nxt;
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gated by reset so a held DIV cannot raise busy while the stage is being reset.
  assign o_busy   = rst && ((r_state == IDLE && i_start) || (r_state == RUN));
  assign o_done   = (r_state == DONE);
  assign o_result = {r_rem, r_quot};

endmodule

// File: rtl/stage_two.sv
// Execute stage: stage-three forwarding, single-cycle ALU, iterative DIV, output flop.
// Define STAGE_TWO_ITER_MUL_EN to run MUL through the 16-cycle iterative engine.
module stage_two
  import alu_pkg::*;
#(
  parameter int DIV_CYCLES = alu_pkg::DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  memc_t       in_memc,
  input  logic        in_reg_wr,
  input  in_t         in_alu,
  input  logic        in_haz1,
  input  logic        in_haz2,
  input  logic        in_haz8,
  input  logic        in_R0_en,
  input  control_e    in_alu_ctrl,
  input  logic [15:0] in_instr,
  input  logic [15:0] in_R1_data,
  input  logic [31:0] s3_data,
  output logic [31:0] s2_alu,
  output logic        s2_R0_en,
  output logic        busy,
  output memc_t       out_memc,
  output logic        out_reg_wr,
  output logic        out_R0_en,
  output logic [15:0] out_instr,
  output logic [15:0] out_R1_data,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_div0
);

  logic [15:0] w_a;
  logic [15:0] w_b;
  logic [15:0] w_r1;
  logic [15:0] w_sum;
  logic [15:0] w_diff;
  logic        w_mul_iter;
  logic        w_start;
  logic        w_busy;
  logic        w_done;
  logic [31:0] w_iter_result;
  logic [31:0] w_alu;
  logic        w_ovf;
  logic        w_div0;
  logic        w_unused_s3;

  assign w_a  = in_haz1 ? s3_data[15:0] : in_alu.a;
  assign w_b  = in_haz2 ? s3_data[15:0] : in_alu.b;
  assign w_r1 = in_haz8 ? s3_data[15:0] : in_R1_data;
  assign w_unused_s3 = ^s3_data[31:16];

  assign w_sum  = w_a + w_b;
  assign w_diff = w_a - w_b;

`ifdef STAGE_TWO_ITER_MUL_EN
  assign w_mul_iter = (in_alu_ctrl == ALU_MUL);
`else
  assign w_mul_iter = 1'b0;
`endif

  // Divide by zero never starts the engine; it resolves in a single cycle below.
  assign w_start = w_mul_iter || ((in_alu_ctrl == ALU_DIV) && (w_b != 16'd0));

  iter_divider #(
    .CYCLES (DIV_CYCLES)
  ) u_iter (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_mul    (w_mul_iter),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_busy   (w_busy),
    .o_done   (w_done),
    .o_result (w_iter_result)
  );

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    w_alu  = '0;
    w_ovf  = 1'b0;
    w_div0 = 1'b0;
    if (w_done) begin
      w_alu = w_iter_result;
    end else begin
      unique case (in_alu_ctrl)
        ALU_ADD: begin
          w_alu[15:0] = w_sum;
          w_ovf       = signed_ovf(w_a[15], w_b[15], w_sum[15], 1'b0);
        end
        ALU_SUB: begin
          w_alu[15:0] = w_diff;
          w_ovf       = signed_ovf(w_a[15], w_b[15], w_diff[15], 1'b1);
        end
        ALU_AND: w_alu[15:0] = w_a & w_b;
        ALU_OR:  w_alu[15:0] = w_a | w_b;
        ALU_SLL: w_alu[15:0] = w_a << w_b[3:0];
        ALU_SRL: w_alu[15:0] = w_a >> w_b[3:0];
`ifndef STAGE_TWO_ITER_MUL_EN
        ALU_MUL: w_alu = {16'd0, w_a} * {16'd0, w_b};
`endif
        ALU_DIV: w_div0 = (w_b == 16'd0);
        default: w_alu = '0;
      endcase
    end
  end

  // While the engine is busy the memory stage receives an all-zero bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_memc     <= '0;
      out_reg_wr   <= 1'b0;
      out_R0_en    <= 1'b0;
      out_instr    <= '0;
      out_R1_data  <= '0;
      out_result   <= '0;
      out_overflow <= 1'b0;
      out_div0     <= 1'b0;
    end else if (w_busy) begin
      out_memc     <= '0;
      out_reg_wr   <= 1'b0;
      out_R0_en    <= 1'b0;
      out_instr    <= '0;
      out_R1_data  <= '0;
      out_result   <= '0;
      out_overflow <= 1'b0;
      out_div0     <= 1'b0;
    end else begin
      out_memc     <= in_memc;
      out_reg_wr   <= in_reg_wr;
      out_R0_en    <= in_R0_en;
      out_instr    <= in_instr;
      out_R1_data  <= w_r1;
      out_result   <= w_alu;
      out_overflow <= w_ovf;
      out_div0     <= w_div0;
    end
  end

  assign s2_alu   = w_alu;
  assign s2_R0_en = in_R0_en;
  assign busy     = w_busy;

endmodule

// File: tb/tb_stage_two.sv
// Self-checking bench for stage_two: vector table, randomized ops against an
// arithmetic reference model, and multi-cycle DIV/MUL/reset sequences.
`timescale 1ns/1ps
module tb_stage_two;
  import alu_pkg::*;

  localparam int NCYC = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  memc_t       in_memc;
  logic        in_reg_wr;
  in_t         in_alu;
  logic        in_haz1, in_haz2, in_haz8, in_R0_en;
  control_e    in_alu_ctrl;
  logic [15:0] in_instr, in_R1_data;
  logic [31:0] s3_data;
  logic [31:0] s2_alu;
  logic        s2_R0_en, busy;
  memc_t       out_memc;
  logic        out_reg_wr, out_R0_en;
  logic [15:0] out_instr, out_R1_data;
  logic [31:0] out_result;
  logic        out_overflow, out_div0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stage_two #(.DIV_CYCLES(NCYC)) dut (
    .clk(clk), .rst(rst), .in_memc(in_memc), .in_reg_wr(in_reg_wr), .in_alu(in_alu),
    .in_haz1(in_haz1), .in_haz2(in_haz2), .in_haz8(in_haz8), .in_R0_en(in_R0_en),
    .in_alu_ctrl(in_alu_ctrl), .in_instr(in_instr), .in_R1_data(in_R1_data),
    .s3_data(s3_data), .s2_alu(s2_alu), .s2_R0_en(s2_R0_en), .busy(busy),
    .out_memc(out_memc), .out_reg_wr(out_reg_wr), .out_R0_en(out_R0_en),
    .out_instr(out_instr), .out_R1_data(out_R1_data), .out_result(out_result),
    .out_overflow(out_overflow), .out_div0(out_div0)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        div0;
  } ref_t;

  typedef struct {
    string       tag;
    control_e    op;
    logic [15:0] a, b;
    logic        h1, h2, h8;
    logic [31:0] s3;
    logic [15:0] r1;
    logic [31:0] exp_res;
    logic        exp_ovf, exp_div0;
    logic [15:0] exp_r1;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the effective operands.
  function automatic ref_t ref_calc(input control_e op, input logic [15:0] a, input logic [15:0] b);
    ref_t r;
    int   sa, sb, s;
    r  = '0;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      ALU_ADD: begin s = sa + sb; r.res = (32'(a) + 32'(b)) & 32'hFFFF; r.ovf = (s > 32767) || (s < -32768); end
      ALU_SUB: begin s = sa - sb; r.res = (32'(a) - 32'(b)) & 32'hFFFF; r.ovf = (s > 32767) || (s < -32768); end
      ALU_AND: r.res = 32'(a & b);
      ALU_OR:  r.res = 32'(a | b);
      ALU_SLL: r.res = (32'(a) << b[3:0]) & 32'hFFFF;
      ALU_SRL: r.res = 32'(a) >> b[3:0];
      ALU_MUL: r.res = 32'(a) * 32'(b);
      ALU_DIV: begin
        if (b == 16'd0) r.div0 = 1'b1;
        else r.res = ((32'(a) % 32'(b)) << 16) | (32'(a) / 32'(b));
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic idle_inputs();
    in_alu_ctrl = ALU_AND; in_alu = '0; in_haz1 = 0; in_haz2 = 0; in_haz8 = 0;
    s3_data = '0; in_R1_data = '0; in_instr = '0; in_memc = '0; in_reg_wr = 0; in_R0_en = 0;
  endtask

  // Entered and left just after a falling edge.
  task automatic run_single(input string tag, input control_e op, input logic [15:0] a,
                            input logic [15:0] b, input logic h1, input logic h2, input logic h8,
                            input logic [31:0] s3, input logic [15:0] r1, input logic [31:0] exp_res,
                            input logic exp_ovf, input logic exp_div0, input logic [15:0] exp_r1);
    logic [15:0] instr;
    logic [3:0]  mc;
    logic        r0;
    instr = 16'($urandom); mc = 4'($urandom); r0 = 1'($urandom);
    in_alu_ctrl = op; in_alu.a = a; in_alu.b = b; in_haz1 = h1; in_haz2 = h2; in_haz8 = h8;
    s3_data = s3; in_R1_data = r1; in_instr = instr; in_memc = mc; in_reg_wr = 1; in_R0_en = r0;
    #1;
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " s2_alu"}, s2_alu, exp_res);
    check({tag, " s2_R0_en"}, 32'(s2_R0_en), 32'(r0));
    @(posedge clk); #1;
    check({tag, " result"}, out_result, exp_res);
    check({tag, " ovf/div0"}, {30'd0, out_overflow, out_div0}, {30'd0, exp_ovf, exp_div0});
    check({tag, " R1_data"}, 32'(out_R1_data), 32'(exp_r1));
    check({tag, " passthru"}, {10'd0, out_instr, out_memc, out_reg_wr, out_R0_en},
          {10'd0, instr, mc, 1'b1, r0});
    @(negedge clk);
  endtask

  // Multi-cycle op with a forwarded through s3_data, which is scrambled once accepted.
  task automatic run_multi(input string tag, input control_e op, input logic [15:0] a,
                           input logic [15:0] b, input logic [31:0] exp_res);
    int          n;
    bit          bub_ok, done;
    logic        bsy;
    logic [15:0] instr;
    logic [3:0]  mc;
    logic        r0;
    logic [31:0] res;
    logic [21:0] side;
    instr = 16'($urandom) | 16'h0001; mc = 4'($urandom); r0 = 1'($urandom);
    in_alu_ctrl = op; in_alu.a = 16'($urandom); in_alu.b = b; in_haz1 = 1; in_haz2 = 0; in_haz8 = 0;
    s3_data = {16'($urandom), a}; in_R1_data = 16'($urandom); in_instr = instr; in_memc = mc;
    in_reg_wr = 1; in_R0_en = r0;
    n = 0; bub_ok = 1; done = 0; res = '0; side = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1 bsy = busy;
      @(posedge clk); #1;
      if (bsy) begin
        n++;
        s3_data = $urandom;
        if ({out_instr, out_memc, out_reg_wr, out_R0_en, out_overflow, out_div0} != '0 ||
            out_result != '0 || out_R1_data != '0) bub_ok = 0;
      end else begin
        done = 1;
        res  = out_result;
        side = {out_instr, out_memc, out_reg_wr, out_R0_en};
      end
      @(negedge clk);
    end
    check({tag, " completed"}, 32'(done), 32'd1);
    check({tag, " busy cycles"}, 32'(n), 32'(NCYC + 1));
    check({tag, " bubbles"}, 32'(bub_ok), 32'd1);
    check({tag, " result"}, res, exp_res);
    check({tag, " passthru"}, {10'd0, side}, {10'd0, instr, mc, 1'b1, r0});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t     vecs[$];
    ref_t     m;
    control_e op;
    logic [15:0] a, b, r1;
    logic        h1, h2, h8;
    logic [31:0] s3;

    idle_inputs();
    in_alu_ctrl = ALU_DIV; in_alu.a = 16'h0064; in_alu.b = 16'h0007;
    repeat (2) @(negedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset result", out_result, 32'd0);
    check("reset side", {10'd0, out_instr, out_memc, out_reg_wr, out_R0_en},  32'd0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;

    vecs.push_back('{"add_ovf",  ALU_ADD, 16'h7FFF, 16'h0001, 0, 0, 0, 32'h0, 16'h1234, 32'h0000_8000, 1, 0, 16'h1234});
    vecs.push_back('{"add_wrap", ALU_ADD, 16'hFFFF, 16'h0001, 0, 0, 0, 32'h0, 16'h0000, 32'h0000_0000, 0, 0, 16'h0000});
    vecs.push_back('{"sub_ovf",  ALU_SUB, 16'h8000, 16'h0001, 0, 0, 0, 32'h0, 16'h0000, 32'h0000_7FFF, 1, 0, 16'h0000});
    vecs.push_back('{"sub_neg",  ALU_SUB, 16'h0000, 16'h0001, 0, 0, 0, 32'h0, 16'h0000, 32'h0000_FFFF, 0, 0, 16'h0000});
    vecs.push_back('{"fwd_a",    ALU_SUB, 16'h5555, 16'h0003, 1, 0, 0, 32'h0000_0010, 16'h0000, 32'h0000_000D, 0, 0, 16'h0000});
    vecs.push_back('{"fwd_b",    ALU_ADD, 16'h0001, 16'h9999, 0, 1, 0, 32'hABCD_0002, 16'h0000, 32'h0000_0003, 0, 0, 16'h0000});
    vecs.push_back('{"fwd_r1",   ALU_AND, 16'h0000, 16'h0000, 0, 0, 1, 32'h2222_3333, 16'h1111, 32'h0000_0000, 0, 0, 16'h3333});
    vecs.push_back('{"and",      ALU_AND, 16'hF0F0, 16'h3C3C, 0, 0, 0, 32'h0, 16'h0000, 32'h0000_3030, 0, 0, 16'h0000});
    vecs.push_back('{"or",       ALU_OR,  16'hF0F0, 16'h0F01, 0, 0, 0, 32'h0, 16'h0000, 32'h0000_FFF1, 0, 0, 16'h0000});
    vecs.push_back('{"sll",      ALU_SLL, 16'h0001, 16'h0013, 0, 0, 0, 32'h0, 16'h0000, 32'h0000_0008, 0, 0, 16'h0000});
    vecs.push_back('{"srl",      ALU_SRL, 16'h8000, 16'h000F, 0, 0, 0, 32'h0, 16'h0000, 32'h0000_0001, 0, 0, 16'h0000});
    vecs.push_back('{"div0",     ALU_DIV, 16'h0005, 16'h0000, 0, 0, 0, 32'h0, 16'h0000, 32'h0000_0000, 0, 1, 16'h0000});
    vecs.push_back('{"div0_fwd", ALU_DIV, 16'h0005, 16'h0007, 0, 1, 0, 32'h0001_0000, 16'h0000, 32'h0000_0000, 0, 1, 16'h0000});
`ifndef STAGE_TWO_ITER_MUL_EN
    vecs.push_back('{"mul",      ALU_MUL, 16'h1234, 16'h0100, 0, 0, 0, 32'h0, 16'h0000, 32'h0012_3400, 0, 0, 16'h0000});
    vecs.push_back('{"mul_max",  ALU_MUL, 16'hFFFF, 16'hFFFF, 0, 0, 0, 32'h0, 16'h0000, 32'hFFFE_0001, 0, 0, 16'h0000});
`endif
    foreach (vecs[i])
      run_single(vecs[i].tag, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].h1, vecs[i].h2, vecs[i].h8,
                 vecs[i].s3, vecs[i].r1, vecs[i].exp_res, vecs[i].exp_ovf, vecs[i].exp_div0, vecs[i].exp_r1);

    // Reset with non-zero registered outputs clears them asynchronously.
    run_single("pre_rst", ALU_OR, 16'h00F0, 16'h0F00, 0, 0, 0, 32'h0, 16'hBEEF, 32'h0000_0FF0, 0, 0, 16'hBEEF);
    rst = 1'b0; #1;
    check("async rst result", out_result, 32'd0);
    check("async rst side", {out_R1_data, out_instr}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 200; k++) begin
`ifdef STAGE_TWO_ITER_MUL_EN
      op = control_e'(3'($urandom_range(0, 5)));
`else
      op = control_e'(3'($urandom_range(0, 6)));
`endif
      a = 16'($urandom); b = 16'($urandom); r1 = 16'($urandom); s3 = $urandom;
      h1 = 1'($urandom); h2 = 1'($urandom); h8 = 1'($urandom);
      if (k % 4 == 0) a = 16'h7FFF + 16'($urandom_range(0, 2));
      m = ref_calc(op, h1 ? s3[15:0] : a, h2 ? s3[15:0] : b);
      run_single("rand", op, a, b, h1, h2, h8, s3, r1, m.res, m.ovf, m.div0, h8 ? s3[15:0] : r1);
    end

    run_multi("div_100_7", ALU_DIV, 16'd100, 16'd7, 32'h0002_000E);
    run_multi("div_b2b", ALU_DIV, 16'hFFFF, 16'h0001, 32'h0000_FFFF);
    run_multi("div_small", ALU_DIV, 16'h0001, 16'hFFFF, 32'h0001_0000);
    for (int k = 0; k < 8; k++) begin
      a = 16'($urandom);
      b = (k < 4) ? 16'($urandom_range(1, 20)) : 16'($urandom_range(1, 65535));
      m = ref_calc(ALU_DIV, a, b);
      run_multi("div_rand", ALU_DIV, a, b, m.res);
    end

`ifdef STAGE_TWO_ITER_MUL_EN
    run_multi("imul", ALU_MUL, 16'h1234, 16'h0100, 32'h0012_3400);
    run_multi("imul_zero", ALU_MUL, 16'h1234, 16'h0000, 32'h0000_0000);
    for (int k = 0; k < 4; k++) begin
      a = 16'($urandom); b = 16'($urandom);
      m = ref_calc(ALU_MUL, a, b);
      run_multi("imul_rand", ALU_MUL, a, b, m.res);
    end
`endif

    // Reset in the middle of RUN, then a fresh divide.
    in_alu_ctrl = ALU_DIV; in_alu.a = 16'hFFFF; in_alu.b = 16'h0003; in_haz1 = 0; in_haz2 = 0;
    in_reg_wr = 1; in_R0_en = 1; in_instr = 16'h5A5A;
    repeat (9) @(negedge clk);
    #1;
    check("mid_run busy before rst", 32'(busy), 32'd1);
    rst = 1'b0; #1;
    check("mid_run rst busy", 32'(busy), 32'd0);
    check("mid_run rst result", out_result, 32'd0);
    @(posedge clk); #1;
    check("mid_run rst held", {16'd0, out_instr}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_multi("div_after_rst", ALU_DIV, 16'hFFFF, 16'h0010, 32'h000F_0FFF);
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
